// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 FSM states, odd-parity helper and default timing constants.
package ps2_pkg;
  localparam int PS2_INHIBIT_CYCLES = 6_000;
  localparam int PS2_TIMEOUT_CYCLES = 750_000;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } ps2_state_t;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronisers for the PS/2 clock/data lines plus a clock falling-edge pulse.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_sync_clk,
  output logic o_sync_data,
  output logic o_fall
);
  logic [2:0] r_clk_s;
  logic [1:0] r_dat_s;
  // Idle lines are pulled up, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s <= '1;
      r_dat_s <= '1;
    end else begin
      r_clk_s <= {r_clk_s[1:0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_data};
    end
  end
  assign o_sync_clk  = r_clk_s[1];
  assign o_sync_data = r_dat_s[1];
  assign o_fall      = r_clk_s[2] & ~r_clk_s[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// Define PS2_TX_RETRY_EN to resend once after the first NACK or watchdog timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Data,
  output logic       oPs2_Clk_Oe,
  output logic       oPs2_Data_Oe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  // The line must be held low for at least 100us before the request.
  if (INHIBIT_CYCLES < CLK_FREQ_HZ / 10_000) begin : g_bad_inhibit
    $error("INHIBIT_CYCLES shorter than 100us");
  end
  ps2_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [7:0]    r_data;
  logic          r_par;
  logic          r_retried;
  logic          w_sync_clk;
  logic          w_sync_data;
  logic          w_fall;
  logic          w_watch;
  logic          w_fail;
  logic          w_retry;
  logic [9:0]    w_frame;
  ps2_line_sync u_sync (
    .i_clk      (iClk),
    .i_rst      (iReset),
    .i_ps2_clk  (iPs2_Clk),
    .i_ps2_data (iPs2_Data),
    .o_sync_clk (w_sync_clk),
    .o_sync_data(w_sync_data),
    .o_fall     (w_fall)
  );
  assign w_frame = {1'b1, r_par, r_data};
  assign w_watch = (r_state != S_IDLE) && (r_state != S_INHIBIT);
  // A fall coinciding with expiry wins; an ACK-slot high data line is a NACK.
  assign w_fail  = (w_watch && !w_fall && r_cnt == TO_LAST) ||
                   (r_state == S_ACK && w_fall && w_sync_data);
  assign w_retry = RETRY && !r_retried;
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_data       <= '0;
      r_par        <= 1'b0;
      r_retried    <= 1'b0;
      oPs2_Clk_Oe  <= 1'b0;
      oPs2_Data_Oe <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oErr         <= 1'b0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      case (r_state)
        S_IDLE: if (iStart) begin
          r_data      <= iData;
          r_par       <= odd_parity(iData);
          r_retried   <= 1'b0;
          r_cnt       <= '0;
          oBusy       <= 1'b1;
          oPs2_Clk_Oe <= 1'b1;
          r_state     <= S_INHIBIT;
        end
        S_INHIBIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == INH_DATA) oPs2_Data_Oe <= 1'b1;
          if (r_cnt == INH_LAST) begin
            oPs2_Clk_Oe <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_RELEASE;
          end
        end
        default: begin
          r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
          if (w_fail) begin
            oPs2_Clk_Oe  <= w_retry;
            oPs2_Data_Oe <= 1'b0;
            r_cnt        <= '0;
            r_retried    <= 1'b1;
            r_state      <= w_retry ? S_INHIBIT : S_IDLE;
            oErr         <= !w_retry;
            oBusy        <= w_retry;
          end else if (r_state == S_RELEASE) begin
            r_idx   <= '0;
            r_state <= S_SHIFT;
          end else if (r_state == S_SHIFT && w_fall) begin
            // Falls 1..10 put data bits, parity, then the released stop bit.
            r_idx        <= r_idx + 1'b1;
            oPs2_Data_Oe <= ~w_frame[r_idx];
            if (r_idx == 4'd9) r_state <= S_ACK;
          end else if (r_state == S_ACK && w_fall) begin
            r_state <= S_WAIT_IDLE;
          end else if (r_state == S_WAIT_IDLE && w_sync_clk && w_sync_data) begin
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + random frames against a behavioural PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 30;
  localparam int TO  = 200;
  localparam int H   = 10;
  logic clk = 1'b0;
  logic iReset, iStart;
  logic [7:0] iData;
  logic dev_clk, dev_data;
  logic line_clk, line_data;
  logic oPs2_Clk_Oe, oPs2_Data_Oe, oBusy, oDone, oErr;
  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_err = 0, n_rel = 0, n_viol = 0;
  int rel_cyc = 0, err_cyc = 0, inh_run = 0, both_run = 0, inh_last = 0, both_last = 0;
  logic prev_clk_oe = 1'b0;

  assign line_clk  = ~oPs2_Clk_Oe & dev_clk;
  assign line_data = ~oPs2_Data_Oe & dev_data;

  ps2_host_tx #(.CLK_FREQ_HZ(250_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(clk), .iReset(iReset), .iStart(iStart), .iData(iData),
    .iPs2_Clk(line_clk), .iPs2_Data(line_data),
    .oPs2_Clk_Oe(oPs2_Clk_Oe), .oPs2_Data_Oe(oPs2_Data_Oe),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (oDone) n_done++;
    if (oErr) begin n_err++; err_cyc = cyc; end
    if (prev_clk_oe && !oPs2_Clk_Oe && oBusy) begin
      rel_cyc = cyc; n_rel++; inh_last = inh_run; both_last = both_run;
    end
    inh_run  = oPs2_Clk_Oe ? inh_run + 1 : 0;
    both_run = oPs2_Clk_Oe ? both_run + int'(oPs2_Data_Oe) : 0;
    if (!oBusy && (oPs2_Clk_Oe || oPs2_Data_Oe)) n_viol++;
    prev_clk_oe = oPs2_Clk_Oe;
  end

  function automatic logic [10:0] model(input logic [7:0] d);
    return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge clk); iStart = 1'b1; iData = d;
    @(negedge clk); iStart = 1'b0;
  endtask

  task automatic dev(input bit ack, input int npulse, output logic [10:0] bits);
    int n = 0;
    bits = '1;
    while (!(oPs2_Clk_Oe == 1'b0 && line_data == 1'b0) && n < 2000) begin
      @(negedge clk); n++;
    end
    check("dev_wait_request", n < 2000, 1);
    repeat (H) @(negedge clk);
    bits[0] = line_data;
    for (int i = 1; i <= npulse; i++) begin
      dev_clk = 1'b0;
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = line_data;
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oBusy && n < 3000) begin @(negedge clk); n++; end
    check("busy_drop", oBusy, 0);
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input string tag);
    logic [10:0] bits;
    int d0 = n_done, e0 = n_err;
    start(d);
    dev(1'b1, 11, bits);
    wait_idle();
    check({tag, "_bits"}, bits, model(d));
    check({tag, "_done"}, n_done - d0, 1);
    check({tag, "_err"}, n_err - e0, 0);
    check({tag, "_lines"}, {oPs2_Clk_Oe, oPs2_Data_Oe}, 0);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, r0;
    iReset = 1'b1; iStart = 1'b0; iData = '0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {oBusy, oDone, oErr, oPs2_Clk_Oe, oPs2_Data_Oe}, 0);
    iReset = 1'b0;
    frame(8'hED, "ed");
    check("inhibit_len", inh_last, INH);
    check("start_bit_cycles", both_last, 1);
    frame(8'h01, "x01");
    frame(8'hFF, "xff");
    for (int i = 0; i < 5; i++) frame(8'($urandom_range(0, 255)), "rand");
    // NACK: device leaves data high in the ack slot
    d0 = n_done; e0 = n_err;
    start(8'h5A);
    dev(1'b0, 11, bits);
    check("nack_bits", bits, model(8'h5A));
`ifdef PS2_TX_RETRY_EN
    check("nack_first_silent", n_err - e0, 0);
    dev(1'b0, 11, bits);
    check("nack_retry_bits", bits, model(8'h5A));
`endif
    wait_idle();
    check("nack_err", n_err - e0, 1);
    check("nack_done", n_done - d0, 0);
    // iStart while busy must be ignored
    start(8'h3C);
    repeat (5) @(negedge clk);
    check("busy_during_frame", oBusy, 1);
    start(8'hC3);
    dev(1'b1, 11, bits);
    wait_idle();
    check("busy_ignore_bits", bits, model(8'h3C));
    // reset after the 5th fall
    d0 = n_done; e0 = n_err;
    start(8'h96);
    dev(1'b1, 5, bits);
    @(negedge clk); iReset = 1'b1;
    @(negedge clk);
    check("midrst_outs", {oBusy, oDone, oErr, oPs2_Clk_Oe, oPs2_Data_Oe}, 0);
    iReset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_pulse", (n_done - d0) + (n_err - e0), 0);
    frame(8'h69, "post_rst");
    // device never clocks
    d0 = n_done; e0 = n_err; r0 = n_rel;
    start(8'hA5);
    wait_idle();
    check("to_err", n_err - e0, 1);
    check("to_done", n_done - d0, 0);
    check("to_latency", err_cyc - rel_cyc, TO);
`ifdef PS2_TX_RETRY_EN
    check("to_releases", n_rel - r0, 2);
`else
    check("to_releases", n_rel - r0, 1);
`endif
    check("to_lines", {oPs2_Clk_Oe, oPs2_Data_Oe}, 0);
    check("oe_outside_busy", n_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
